// File: rtl/sprite_palette_ram.sv
// Multi-palette colour lookup for sprite pixels: runtime-writable RAM of RGB words,
// a two-stage read pipeline with saturating brightness fade, and a transparency flag.
//
// state | meaning
// CLEAR | sweep every RAM word to zero after reset; busy high, reads and writes ignored
// RUN   | normal operation; writes land in RAM, reads flow through the pipeline
module sprite_palette_ram #(
    parameter int INDEX_W           = 4,
    parameter int CH_W              = 4,
    parameter int NUM_PALETTES      = 4,
    parameter int TRANSPARENT_INDEX = 0,
    localparam int PAL_W            = $clog2(NUM_PALETTES)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    output logic                busy,
    input  logic                wr_en,
    input  logic [PAL_W-1:0]    wr_pal,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0]   wr_rgb,
    input  logic                rd_en,
    input  logic [PAL_W-1:0]    rd_pal,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [CH_W-1:0]     fade,
    output logic                out_valid,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                transparent
);

    localparam int ADDR_W = PAL_W + INDEX_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WORD_W = 3 * CH_W;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                rd_accept;
    logic [ADDR_W-1:0]   rd_addr;

    logic [WORD_W-1:0]   mem [DEPTH];

    logic                s1_valid;
    logic [WORD_W-1:0]   s1_word;
    logic [CH_W-1:0]     s1_fade;
    logic                s1_transp;
    logic [CH_W-1:0]     s1_red, s1_green, s1_blue;

    function automatic logic [CH_W-1:0] sat_sub(input logic [CH_W-1:0] c,
                                                input logic [CH_W-1:0] f);
        return (c > f) ? (c - f) : '0;
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        rd_accept = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end
            end
            RUN: begin
                mem_we    = wr_en;
                mem_waddr = {wr_pal, wr_index};
                mem_wdata = wr_rgb;
                rd_accept = rd_en;
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    assign busy    = (state_q == CLEAR);
    assign rd_addr = {rd_pal, rd_index};

    // RAM contents are deliberately not reset; the CLEAR sweep zeroes them.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------- stage 1: RAM read (old data on same-address write) ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid  <= 1'b0;
            s1_word   <= '0;
            s1_fade   <= '0;
            s1_transp <= 1'b0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_word   <= mem[rd_addr];
                s1_fade   <= fade;
                s1_transp <= (rd_index == INDEX_W'(TRANSPARENT_INDEX));
            end
        end
    end

    assign s1_red   = s1_word[3*CH_W-1 -: CH_W];
    assign s1_green = s1_word[2*CH_W-1 -: CH_W];
    assign s1_blue  = s1_word[CH_W-1 -: CH_W];

    // ---------------- stage 2: fade and output hold ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid   <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                red         <= sat_sub(s1_red, s1_fade);
                green       <= sat_sub(s1_green, s1_fade);
                blue        <= sat_sub(s1_blue, s1_fade);
                transparent <= s1_transp;
            end
        end
    end

endmodule

// File: doc/sprite_palette_ram.md
# sprite_palette_ram

Programmable, multi-palette colour lookup for sprite rendering: maps a sprite pixel's colour index to 4-bit-per-channel RGB. Holds NUM_PALETTES independent palettes of 2^INDEX_W entries in internal RAM, written at runtime by the sprite/game controller instead of being hard-wired. Adds per-read brightness fade and a transparency flag. Sits between the sprite ROM index output and the VGA colour mux; self-clears its RAM after reset.

## Interface
- INDEX_W, 4, colour index width; entries per palette = 2^INDEX_W
- CH_W, 4, bits per colour channel
- NUM_PALETTES, 4, palette count (power of two, >= 2); PAL_W = log2(NUM_PALETTES)
- TRANSPARENT_INDEX, 0, index value reported as transparent
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- busy  out  1  high while post-reset clear sequence runs
- wr_en  in  1  write strobe
- wr_pal  in  PAL_W  palette select for write
- wr_index  in  INDEX_W  entry select for write
- wr_rgb  in  3*CH_W  {red, green, blue} write data
- rd_en  in  1  read request
- rd_pal  in  PAL_W  palette select for read
- rd_index  in  INDEX_W  colour index to look up
- fade  in  CH_W  brightness reduction, sampled with rd_en
- out_valid  out  1  red/green/blue/transparent valid
- red, green, blue  out  CH_W each  looked-up, faded colour
- transparent  out  1  rd_index == TRANSPARENT_INDEX for this result

## Operation
- Storage: DEPTH = NUM_PALETTES * 2^INDEX_W words of 3*CH_W bits; address = {pal, index}.
- FSM states: CLEAR, RUN.
- CLEAR: entered asynchronously on Reset_n low; counter reset to 0. Each Clk edge with Reset_n high writes 0 to address counter, counter increments; after address DEPTH-1 is written, next state RUN. busy = (state == CLEAR).
- RUN: wr_en writes wr_rgb to {wr_pal, wr_index}. busy = 0.
- wr_en and rd_en during CLEAR ignored (no RAM write, no out_valid).
- Read pipeline (RUN only): stage 1 registers RAM word at {rd_pal, rd_index}, plus fade and index-match flag; stage 2 computes per channel max(c - fade, 0) (saturating, CH_W-bit, no wrap), registers outputs and out_valid.
- Transparent result: colour still output from RAM; transparent = 1 only flags it.
- Fully pipelined: one read per cycle, back-to-back rd_en gives back-to-back out_valid.
- Collision: write and read same address same cycle -> read returns old data; read one cycle after write returns new data.
- When out_valid = 0, red/green/blue/transparent hold last value.

## Timing
- Reset values: busy 1, out_valid 0, red/green/blue 0, transparent 0, state CLEAR, counter 0, pipeline valids 0. RAM contents not reset asynchronously; cleared by CLEAR.
- busy high for exactly DEPTH rising edges after Reset_n release (64 with defaults); first accepted write/read on the edge where busy is first sampled 0.
- Read latency 2: rd_en sampled at edge N -> out_valid and data at edge N+2, out_valid high for one cycle per request.
- Reset_n asserted mid-operation: in-flight reads dropped, out_valid 0 immediately, CLEAR restarts from address 0 after release.
- fade = 0 passes colour unchanged; fade = 2^CH_W-1 forces 0.

## Test plan
- Reset release: busy high 64 cycles then low; reads of every {pal,index} after return 0x000 with out_valid 2 cycles after each rd_en.
- Write pal 1 idx 5 = 0xE00, pal 2 idx 5 = 0x0A6; read pal 1 idx 5 -> red E green 0 blue 0; pal 2 idx 5 -> 0,A,6; pal 0 idx 5 -> 0,0,0.
- Write idx 3 = 0xB96, read with fade 4 -> 7,5,2; fade 9 -> 2,0,0; fade F -> 0,0,0.
- Same-cycle write 0x123 / read of an address holding 0x456 -> 4,5,6; read next cycle -> 1,2,3.
- 16 consecutive rd_en over idx 0..15 -> 16 consecutive out_valid, transparent high only for idx 0.
- Reset_n pulsed low mid-stream with reads in flight -> out_valid drops at once, busy high 64 cycles, previously written entries read back 0x000.
